div: RTL and testbench
======================

# div

Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU. EX raises a start request with both operands, stalls until `ready_o`, then forwards `result_o` to the HI/LO write path. The remainder goes to HI and the quotient to LO. The unit uses one shift-subtract step per cycle and holds its result until EX withdraws the request.

## Interface
Parameters: none (widths fixed by `RegBus` = 32, `DoubleRegBus` = 64).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `signed_div_i`  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request; level-sensitive, held by EX until it consumes the result.
- `annul_i`  in  1  abort an in-flight divide (pipeline flush).
- `result_o`  out  64  `{remainder[31:0], quotient[31:0]}`, valid while `ready_o` = 1.
- `ready_o`  out  1  result valid.

## Operation
- States: FREE, BYZERO, ON, END. Reset state is FREE, with `result_o` = 0, `ready_o` = 0, iteration counter = 0.
- FREE:
  - If `start_i` = 1 and `annul_i` = 0, capture the operands.
  - If the divisor is 0, go to BYZERO; otherwise go to ON with counter = 0.
  - `start_i` = 0, or `annul_i` = 1, leaves the state in FREE.
- Operand capture: in signed mode, each negative operand is replaced by its two's complement (magnitude). `0x80000000` stays `0x80000000` and is treated as an unsigned magnitude.
- ON:
  - While counter < 32, perform one restoring step per edge and increment the counter.
  - A restoring step shifts the 65-bit work register left by 1, trial-subtracts the divisor from the upper 33 bits, and shifts in 1 if the result is non-negative (keeping the difference), else 0.
  - When counter = 32, apply the sign fix-up, go to END, drive `result_o`, and set `ready_o` = 1.
- BYZERO: the next edge goes to END with `result_o` = 0 and `ready_o` = 1.
- Sign fix-up (signed mode only):
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend is negative.
  - `0x80000000 / 0xFFFFFFFF` gives quotient `0x80000000`, remainder 0 (wrap, no trap).
- END:
  - While `start_i` = 1, hold `result_o` and `ready_o` = 1.
  - When `start_i` = 0, the next edge goes to FREE and clears `result_o` to 0 and `ready_o` to 0.
  - `annul_i` is ignored in END.
- Annul: `annul_i` = 1 sampled in ON or BYZERO forces FREE on that edge. `ready_o` never rises for the aborted operation.
- Operand inputs are ignored after the capture edge. `start_i` edges while not in FREE are ignored.
- Asynchronous reset at any point forces FREE, `ready_o` = 0, `result_o` = 0 immediately, without waiting for a clock edge.

## Timing
- The accepting edge is edge 0. Normal divide: `ready_o` is high from edge 33 onward (32 steps plus completion).
- Divide by zero: `ready_o` is high from edge 2 onward.
- `result_o` and `ready_o` are registered and change only on rising edges (or on reset).
- A new request is accepted no earlier than the edge after the return to FREE. Minimum spacing between requests is 35 edges.
- Inputs are combinationally unused outside FREE, so no paths run from inputs to outputs.

## Configuration
- `DIV_SIGNED_EN` defined: full signed support as above.
- Not defined: the magnitude conversion and sign fix-up logic is omitted, and `signed_div_i` is ignored. Every divide is unsigned, with the same latency.

## Test plan
- Unsigned 100 / 7 (`signed_div_i` = 0) → `ready_o` at edge 33, `result_o` = `64'h00000002_0000000E`.
- Signed −7 / 2 (`0xFFFFFFF9`, `0x00000002`), macro on → `result_o` = `64'hFFFFFFFF_FFFFFFFD`.
  - Same stimulus with the macro off → `64'h00000001_7FFFFFFC`.
- Divisor 0, dividend `0x12345678` → `ready_o` at edge 2, `result_o` = 0.
- Start, then pulse `annul_i` at counter = 10 → FREE next edge and `ready_o` stays 0. A fresh 9 / 3 request on the following edge yields `64'h00000000_00000003` at its edge 33.
- Hold `start_i` high 5 cycles into END → result stable and `ready_o` = 1. Drop `start_i` → on the next edge `ready_o` = 0, `result_o` = 0.
- Assert `rst` asynchronously mid-ON (counter = 20) → `ready_o` and `result_o` = 0 immediately. After release, a 100 / 7 request completes normally.

Source files
------------

// File: rtl/div.sv
// rtl/div.sv - multi-cycle 32-bit restoring divider for DIV/DIVU
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   signed_div_i    1 = signed divide, 0 = unsigned
//   opdata1_i       dividend (captured on the accepting edge only)
//   opdata2_i       divisor  (captured on the accepting edge only)
//   start_i         level request, held until the result is consumed
//   annul_i         abort an in-flight divide
//   result_o        {remainder, quotient}, valid while ready_o = 1
//   ready_o         result valid
//
// Build option: define DIV_SIGNED_EN for signed support. Without it every
// divide is unsigned and signed_div_i is ignored.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state, next_state;
  logic [5:0]  cnt;
  logic [63:0] work;       // {partial remainder, dividend/quotient bits}
  logic [31:0] divisor;
  logic        neg_q, neg_r;

  logic [31:0] mag1, mag2;
  logic        neg_q_in, neg_r_in;

`ifdef DIV_SIGNED_EN
  // Magnitudes of the operands; 0x80000000 negates to itself, which is
  // exactly its unsigned magnitude.
  always_comb begin
    neg_r_in = signed_div_i & opdata1_i[31];
    neg_q_in = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
    mag1     = neg_r_in ? (~opdata1_i + 32'd1) : opdata1_i;
    mag2     = (signed_div_i & opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  end
`else
  logic unused_signed;
  assign unused_signed = signed_div_i;
  assign neg_r_in      = 1'b0;
  assign neg_q_in      = 1'b0;
  assign mag1          = opdata1_i;
  assign mag2          = opdata2_i;
`endif

  // One restoring step. The shifted-up partial remainder is 33 bits
  // (work[63:31]); when it is >= divisor the difference always fits in
  // 32 bits, so the low 32 bits of the subtraction are sufficient.
  logic        step_ge;
  logic [31:0] step_diff;
  logic [63:0] step_work;

  always_comb begin
    step_ge   = work[63:31] >= {1'b0, divisor};
    step_diff = work[62:31] - divisor;
    step_work = step_ge ? {step_diff, work[30:0], 1'b1} : {work[62:0], 1'b0};
  end

  logic [31:0] fix_quot, fix_rem;

  always_comb begin
    fix_quot = neg_q ? (~work[31:0] + 32'd1) : work[31:0];
    fix_rem  = neg_r ? (~work[63:32] + 32'd1) : work[63:32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FREE;
    end else begin
      state <= next_state;
    end
  end

  // BYZERO stays two edges (cnt 0 then 1) so a zero divide reports on
  // edge 2 after acceptance.
  always_comb begin
    next_state = state;
    case (state)
      FREE: begin
        if (start_i && !annul_i) begin
          next_state = (opdata2_i == 32'd0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        if (annul_i) begin
          next_state = FREE;
        end else if (cnt != 6'd0) begin
          next_state = END;
        end
      end
      ON: begin
        if (annul_i) begin
          next_state = FREE;
        end else if (cnt == 6'd32) begin
          next_state = END;
        end
      end
      END: begin
        if (!start_i) begin
          next_state = FREE;
        end
      end
      default: next_state = FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 6'd0;
      work     <= 64'd0;
      divisor  <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (start_i && !annul_i) begin
            work    <= {32'd0, mag1};
            divisor <= mag2;
            neg_q   <= neg_q_in;
            neg_r   <= neg_r_in;
            cnt     <= 6'd0;
          end
        end
        BYZERO: begin
          if (!annul_i) begin
            cnt <= cnt + 6'd1;
            if (cnt != 6'd0) begin
              result_o <= 64'd0;
              ready_o  <= 1'b1;
            end
          end
        end
        ON: begin
          if (!annul_i) begin
            if (cnt != 6'd32) begin
              work <= step_work;
              cnt  <= cnt + 6'd1;
            end else begin
              result_o <= {fix_rem, fix_quot};
              ready_o  <= 1'b1;
            end
          end
        end
        END: begin
          if (!start_i) begin
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - scoreboard testbench for the div unit
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = 32'd0;
  logic [31:0] opdata2 = 32'd0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [63:0] q_res[$];
  int          q_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on each rise of ready, pop the oldest expectation and compare
  // both the result and the edge on which ready rose.
  initial begin
    logic        prev;
    logic [63:0] e_res;
    int          e_cyc;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready === 1'b1 && prev !== 1'b1) begin
        if (q_res.size() == 0) begin
          check("unexpected_ready", {63'd0, ready}, 64'd0);
        end else begin
          e_res = q_res.pop_front();
          e_cyc = q_cyc.pop_front();
          check("result", result, e_res);
          check("ready_edge", 64'(cyc), 64'(e_cyc));
        end
      end
      prev = ready;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp, input int lat);
    @(negedge clk);
    opdata1    = a;
    opdata2    = b;
    signed_div = s;
    start      = 1'b1;
    @(posedge clk);
    #1;
    q_res.push_back(exp);
    q_cyc.push_back(cyc + lat);
    // operands must be ignored after the capture edge
    opdata1 = ~a;
    opdata2 = b ^ 32'h5A5A_0001;
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", {63'd0, ready}, 64'd1);
  endtask

  task automatic finish_op(input logic [63:0] exp, input int hold);
    wait_ready();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ready", {63'd0, ready}, 64'd1);
      check("hold_result", result, exp);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("clear_ready", {63'd0, ready}, 64'd0);
    check("clear_result", result, 64'd0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [63:0] exp, input int lat, input int hold);
    issue(a, b, s, exp, lat);
    finish_op(exp, hold);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 5);
    run(32'hFFFF_FFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33, 1);
`ifdef DIV_SIGNED_EN
    run(32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 1);
    run(32'd20, 32'hFFFF_FFFA, 1'b1, 64'h00000002_FFFFFFFD, 33, 1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 33, 1);
`else
    run(32'hFFFF_FFF9, 32'd2, 1'b1, 64'h00000001_7FFFFFFC, 33, 1);
    run(32'd20, 32'hFFFF_FFFA, 1'b1, 64'h00000014_00000000, 33, 1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h80000000_00000000, 33, 1);
`endif
    run(32'h1234_5678, 32'd0, 1'b0, 64'd0, 2, 2);

    // Annul at counter = 10, then a fresh 9 / 3 on the following edge.
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    check("annul_ready", {63'd0, ready}, 64'd0);
    @(negedge clk);
    annul = 1'b0; opdata1 = 32'd9; opdata2 = 32'd3;
    @(posedge clk);
    #1;
    q_res.push_back(64'h00000000_00000003);
    q_cyc.push_back(cyc + 33);
    finish_op(64'h00000000_00000003, 1);

    // Asynchronous reset while a result is being held.
    issue(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
    wait_ready();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_end_ready", {63'd0, ready}, 64'd0);
    check("rst_end_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-ON at counter = 20.
    issue(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_on_ready", {63'd0, ready}, 64'd0);
    check("rst_on_result", result, 64'd0);
    start = 1'b0;
    q_res.delete();
    q_cyc.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_on_no_ready", {63'd0, ready}, 64'd0);

    run(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(q_res.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
